uart_tx_mmio: RTL

- Memory-mapped UART transmitter at data-bus address 0x1100_0000.
- Consumes the uart_en chip-enable produced by the data-bus address decoder.
- CPU writes bytes into a small TX FIFO. A baud-rate FSM serialises them as 8N1 frames, LSB first.
- CPU reads a status word from the same address. A write-stall handshake back-pressures the core when the FIFO is full.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_mmio_if.sv | 25 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_tx_mmio.sv | 134 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   UART_BASE_ADDR : data-bus address the external decoder matches to raise uart_en.
//   ST_*           : bit positions inside the status word returned on loads.
//   tx_state_t     : serialiser FSM state encoding.
package uart_pkg;

   localparam logic [31:0] UART_BASE_ADDR = 32'h1100_0000;

   localparam int ST_BUSY      = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_EMPTY     = 2;
   localparam int ST_COUNT_LSB = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Data-bus slice seen by the UART transmitter.
//   uart_en  : chip-enable from the address decoder
//   d_we     : 1 = store, 0 = load
//   d_wdata  : store data, byte in [7:0]
//   d_rdata  : status word on loads, 0 otherwise
//   d_wait   : stall request while a store hits a full FIFO
interface uart_tx_mmio_if;

   logic        uart_en;
   logic        d_we;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_wait;

   modport master (
      output uart_en, d_we, d_wdata,
      input  d_rdata, d_wait
   );

   modport slave (
      input  uart_en, d_we, d_wdata,
      output d_rdata, d_wait
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through output.
//   push/din   : write din when push=1 and not full
//   pop/dout   : dout always shows the head; pop=1 and not empty advances it
//   full/empty : derived from the occupancy count
//   count      : number of stored entries, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; clearing the pointers and count
   // already makes stale entries unreachable, and it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : data-bus slice (uart_tx_mmio_if.slave); stores push a byte into
//              the TX FIFO, loads return the status word
//              {count[8:4], empty[2], full[1], busy[0]}
//   uart_tx  : registered serial line, idles high
//   tx_irq   : level interrupt, high while FIFO empty and serialiser idle
// The line register is loaded from the current FSM state, so it trails the
// state by one cycle; a byte written on edge N starts its start bit on N+2.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_tx_mmio_if.slave        bus,
   output logic                 uart_tx,
   output logic                 tx_irq
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD;
   localparam int CNT_W    = $clog2(BAUD_DIV);
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

   tx_state_t        state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             bit_end;

   logic             fifo_push;
   logic             fifo_pop;
   logic [7:0]       fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic [AW:0]      fifo_count;

   // Only the low byte of the store data is meaningful.
   logic             unused_wdata;
   assign unused_wdata = ^bus.d_wdata[31:8];

   // The FIFO refuses pushes while full, so a stalled store is retried by the
   // core holding the bus until the first edge where full is low.
   assign fifo_push = bus.uart_en & bus.d_we;
   assign fifo_pop  = (state == IDLE) & ~fifo_empty;
   assign bit_end   = (baud_cnt == CNT_LAST);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (bus.d_wdata[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= 8'hFF;
         uart_tx  <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               uart_tx <= 1'b1;
               if (!fifo_empty) begin
                  shift    <= fifo_dout;
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= START;
               end
            end
            START: begin
               uart_tx <= 1'b0;
               if (bit_end) begin
                  baud_cnt <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            DATA: begin
               uart_tx <= shift[0];
               if (bit_end) begin
                  baud_cnt <= '0;
                  shift    <= {1'b1, shift[7:1]};
                  bit_idx  <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            STOP: begin
               uart_tx <= 1'b1;
               if (bit_end) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign tx_irq     = fifo_empty & (state == IDLE);
   assign bus.d_wait = bus.uart_en & bus.d_we & fifo_full;

   // NOTE: the output is given a default before any condition so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      bus.d_rdata = '0;
      if (bus.uart_en && !bus.d_we) begin
         bus.d_rdata[ST_BUSY]            = (state != IDLE) | ~fifo_empty;
         bus.d_rdata[ST_FULL]            = fifo_full;
         bus.d_rdata[ST_EMPTY]           = fifo_empty;
         bus.d_rdata[ST_COUNT_LSB +: 5]  = 5'(fifo_count);
      end
   end

endmodule
